// File: rtl/multi_dataflow_ctrl_fsm_pkg.sv
// Shared constants for the multi-stream HWPE control FSM.
// State encodings are plain localparams so legacy tools can consume them.
package multi_dataflow_ctrl_package;

    localparam int unsigned N_IN_DEF   = 2;
    localparam int unsigned N_OUT_DEF  = 1;
    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned TILE_W_DEF = 16;
    localparam int unsigned WDOG_W_DEF = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT      = 3'd2;
    localparam logic [2:0] ST_COMPUTE   = 3'd3;
    localparam logic [2:0] ST_NEXT_TILE = 3'd4;
    localparam logic [2:0] ST_TERMINATE = 3'd5;

endpackage

// File: rtl/multi_dataflow_ctrl_fsm_wdog.sv
// Stall watchdog: counts consecutive stalled COMPUTE cycles.
// Only instantiated when MULTI_DATAFLOW_CTRL_WDOG_EN is defined.
module multi_dataflow_ctrl_wdog #(
    parameter int unsigned WDOG_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              active_i,
    input  logic              stall_i,
    input  logic [WDOG_W-1:0] limit_i,
    output logic              expired_o
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;
    logic [WDOG_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + WDOG_W'(1);

    // Leaving COMPUTE or seeing ready zeroes the count, so every entry starts fresh.
    always_comb begin
        cnt_d = '0;
        if (active_i && stall_i && !clear_i) begin
            cnt_d = cnt_inc;
        end
    end

    assign expired_o = active_i && stall_i && !clear_i
                     && (limit_i != '0) && (cnt_inc == limit_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_dataflow_ctrl_fsm.sv
// HWPE control FSM for N_IN sources / N_OUT sinks with tile loop.
// Optional stall watchdog: define MULTI_DATAFLOW_CTRL_WDOG_EN.
module multi_dataflow_ctrl_fsm
    import multi_dataflow_ctrl_package::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned N_OUT  = N_OUT_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned TILE_W = TILE_W_DEF,
    parameter int unsigned WDOG_W = WDOG_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [TILE_W-1:0]      n_tiles_i,
    input  logic [N_OUT*CNT_W-1:0] cnt_limit_i,
    input  logic [WDOG_W-1:0]      wdog_limit_i,
    input  logic [N_IN-1:0]        src_ready_start_i,
    input  logic [N_OUT-1:0]       sink_ready_start_i,
    output logic [N_IN-1:0]        src_req_start_o,
    output logic [N_OUT-1:0]       sink_req_start_o,
    input  logic                   eng_ready_i,
    input  logic [N_OUT*CNT_W-1:0] eng_cnt_i,
    output logic                   eng_start_o,
    output logic                   eng_clear_o,
    output logic                   eng_enable_o,
    output logic [TILE_W-1:0]      tile_idx_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o
);

    logic [2:0]             state_q,    state_d;
    logic [TILE_W-1:0]      tile_idx_q, tile_idx_d;
    logic [TILE_W-1:0]      n_tiles_q,  n_tiles_d;
    logic [N_OUT*CNT_W-1:0] limit_q,    limit_d;
    logic [N_OUT-1:0]       out_done_q, out_done_d;
    logic                   error_q,    error_d;

    logic [N_OUT-1:0] hit;
    logic             all_ready;
    logic             all_done;
    logic             wdog_exp;

    assign all_ready = (&src_ready_start_i) & (&sink_ready_start_i);

    always_comb begin
        hit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            hit[k] = eng_cnt_i[k*CNT_W +: CNT_W] == limit_q[k*CNT_W +: CNT_W];
        end
    end

    assign all_done = &(out_done_q | hit);

`ifdef MULTI_DATAFLOW_CTRL_WDOG_EN
    multi_dataflow_ctrl_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .active_i  (state_q == ST_COMPUTE),
        .stall_i   (!eng_ready_i),
        .limit_i   (wdog_limit_i),
        .expired_o (wdog_exp)
    );
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^wdog_limit_i;
    assign wdog_exp = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        tile_idx_d       = tile_idx_q;
        n_tiles_d        = n_tiles_q;
        limit_d          = limit_q;
        out_done_d       = out_done_q;
        error_d          = error_q;
        src_req_start_o  = '0;
        sink_req_start_o = '0;
        eng_start_o      = 1'b0;
        eng_clear_o      = 1'b0;
        eng_enable_o     = 1'b0;
        done_o           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                eng_clear_o  = 1'b1;
                eng_enable_o = 1'b1;
                if (start_i) begin
                    n_tiles_d  = (n_tiles_i == '0) ? TILE_W'(1) : n_tiles_i;
                    limit_d    = cnt_limit_i;
                    tile_idx_d = '0;
                    out_done_d = '0;
                    error_d    = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START, ST_WAIT: begin
                if (all_ready) begin
                    src_req_start_o  = '1;
                    sink_req_start_o = '1;
                    eng_start_o      = 1'b1;
                    eng_enable_o     = 1'b1;
                    state_d          = ST_COMPUTE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_COMPUTE: begin
                eng_enable_o = 1'b1;
                eng_start_o  = eng_ready_i;
                out_done_d   = out_done_q | hit;
                if (all_done) begin
                    state_d = ST_NEXT_TILE;
                end else if (wdog_exp) begin
                    error_d = 1'b1;
                    state_d = ST_TERMINATE;
                end
            end
            ST_NEXT_TILE: begin
                eng_clear_o  = 1'b1;
                eng_enable_o = 1'b1;
                out_done_d   = '0;
                if (tile_idx_q == n_tiles_q - TILE_W'(1)) begin
                    state_d = ST_TERMINATE;
                end else begin
                    tile_idx_d = tile_idx_q + TILE_W'(1);
                    state_d    = ST_WAIT;
                end
            end
            ST_TERMINATE: begin
                if (all_ready) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear aborts the job silently, even from TERMINATE.
        if (clear_i) begin
            state_d    = ST_IDLE;
            tile_idx_d = '0;
            n_tiles_d  = '0;
            limit_d    = '0;
            out_done_d = '0;
            error_d    = 1'b0;
            done_o     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tile_idx_q <= '0;
            n_tiles_q  <= '0;
            limit_q    <= '0;
            out_done_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tile_idx_q <= tile_idx_d;
            n_tiles_q  <= n_tiles_d;
            limit_q    <= limit_d;
            out_done_q <= out_done_d;
            error_q    <= error_d;
        end
    end

    assign tile_idx_o = tile_idx_q;
    assign busy_o     = state_q != ST_IDLE;
    assign error_o    = error_q;

endmodule

// File: tb/tb_multi_dataflow_ctrl_fsm.sv
// Scoreboard bench for multi_dataflow_ctrl_fsm with a behavioural engine.
// Watchdog scenario runs only when MULTI_DATAFLOW_CTRL_WDOG_EN is defined.
module tb_multi_dataflow_ctrl_fsm;

    localparam int N_IN   = 2;
    localparam int N_OUT  = 2;
    localparam int CNT_W  = 32;
    localparam int TILE_W = 16;
    localparam int WDOG_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clear = 1'b0;
    logic                   start = 1'b0;
    logic [TILE_W-1:0]      n_tiles = 16'd1;
    logic [N_OUT*CNT_W-1:0] cnt_limit = '0;
    logic [WDOG_W-1:0]      wdog_limit = 16'd16;
    logic [N_IN-1:0]        src_rdy = '1;
    logic [N_OUT-1:0]       sink_rdy = '1;
    logic [N_IN-1:0]        src_req;
    logic [N_OUT-1:0]       sink_req;
    logic                   eng_ready = 1'b1;
    logic [N_OUT*CNT_W-1:0] eng_cnt;
    logic                   eng_start, eng_clear, eng_enable;
    logic [TILE_W-1:0]      tile_idx;
    logic                   busy, done, error;

    always #5 clk = ~clk;

    multi_dataflow_ctrl_fsm #(
        .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W),
        .TILE_W(TILE_W), .WDOG_W(WDOG_W)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear),
        .start_i            (start),
        .n_tiles_i          (n_tiles),
        .cnt_limit_i        (cnt_limit),
        .wdog_limit_i       (wdog_limit),
        .src_ready_start_i  (src_rdy),
        .sink_ready_start_i (sink_rdy),
        .src_req_start_o    (src_req),
        .sink_req_start_o   (sink_req),
        .eng_ready_i        (eng_ready),
        .eng_cnt_i          (eng_cnt),
        .eng_start_o        (eng_start),
        .eng_clear_o        (eng_clear),
        .eng_enable_o       (eng_enable),
        .tile_idx_o         (tile_idx),
        .busy_o             (busy),
        .done_o             (done),
        .error_o            (error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine model: counters freeze at cap, count only after a start.
    logic [CNT_W-1:0] cnt [N_OUT];
    logic [CNT_W-1:0] cap [N_OUT];
    logic             started;

    initial begin
        started = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            cnt[k] = '0;
            cap[k] = '0;
        end
    end

    always @(posedge clk) begin
        if (eng_clear) begin
            started <= 1'b0;
            for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
        end else begin
            if (eng_start) started <= 1'b1;
            if (eng_enable && started) begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (cnt[k] < cap[k]) cnt[k] <= cnt[k] + 1;
                end
            end
        end
    end

    always_comb begin
        eng_cnt = '0;
        for (int k = 0; k < N_OUT; k++) eng_cnt[k*CNT_W +: CNT_W] = cnt[k];
    end

    // Scoreboard state.
    typedef struct {
        int   tiles;
        int   bursts;
        int   comp;
        logic err;
    } job_t;

    job_t             exp_q[$];
    int               nt_q[$];
    logic [CNT_W-1:0] lim [N_OUT];
    logic [N_OUT-1:0] seen;
    int               cyc = 0;
    int               tiles_done, bursts, comp_cyc, last_nt, done_cnt;
    logic             all_rdy;

    assign all_rdy = (&src_rdy) & (&sink_rdy);

    initial begin
        done_cnt = 0;
        last_nt  = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic             in_comp;
        logic [N_OUT-1:0] ns;
        job_t             e;
        if (rst_n && !clear) begin
            in_comp = busy && eng_enable && !eng_clear && (src_req == '0);
            if (src_req != '0 || sink_req != '0) begin
                chk("burst_pulse", {src_req, sink_req, eng_start}, 5'h1f);
                chk("burst_ready", all_rdy, 1'b1);
                bursts++;
            end
            if (in_comp) begin
                comp_cyc++;
                ns = seen;
                for (int k = 0; k < N_OUT; k++) begin
                    if (cnt[k] == lim[k]) ns[k] = 1'b1;
                end
                if (&ns && !(&seen)) nt_q.push_back(cyc + 1);
                seen = ns;
            end
            if (busy && eng_clear) begin
                chk("nt_expected", nt_q.size(), 1);
                if (nt_q.size() > 0) chk("nt_cycle", cyc, nt_q.pop_front());
                chk("nt_tile_idx", tile_idx, tiles_done);
                tiles_done++;
                seen    = '0;
                last_nt = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("done_tiles", tiles_done, e.tiles);
                    chk("done_bursts", bursts, e.bursts);
                    chk("done_error", error, e.err);
                    chk("done_tile_idx", tile_idx, (e.tiles == 0) ? 0 : e.tiles - 1);
                    chk("done_comp_cycles", comp_cyc, e.comp);
                    if (!e.err) chk("done_latency", cyc, last_nt + 1);
                end
            end
        end
    end

    task automatic start_job(input int nt,
                             input logic [CNT_W-1:0] l0, input logic [CNT_W-1:0] l1,
                             input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1);
        n_tiles    = TILE_W'(nt);
        cnt_limit  = {l1, l0};
        lim[0]     = l0;
        lim[1]     = l1;
        cap[0]     = c0;
        cap[1]     = c1;
        seen       = '0;
        tiles_done = 0;
        bursts     = 0;
        comp_cyc   = 0;
        nt_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_job(input int t, input int b, input int c, input logic er);
        job_t j;
        j.tiles  = t;
        j.bursts = b;
        j.comp   = c;
        j.err    = er;
        exp_q.push_back(j);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt != d0, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < N_OUT; k++) lim[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_eng_clear", eng_clear, 1'b1);
        chk("rst_eng_enable", eng_enable, 1'b1);
        chk("rst_eng_start", eng_start, 1'b0);
        chk("rst_req", {src_req, sink_req}, 4'h0);
        chk("rst_done_err", {done, error}, 2'b00);
        chk("rst_tile_idx", tile_idx, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single tile, limit 8: cycle-exact start then one done.
        push_job(1, 1, 9, 1'b0);
        start_job(1, 8, 8, 8, 8);
        @(negedge clk);
        chk("t1_req_at_t1", {src_req, sink_req}, 4'hf);
        chk("t1_eng_start", eng_start, 1'b1);
        chk("t1_busy", busy, 1'b1);
        @(negedge clk);
        chk("t1_compute_noreq", {src_req, sink_req}, 4'h0);
        chk("t1_compute_ctl", {eng_enable, eng_clear}, 2'b10);
        wait_done(100);

        // Outputs finishing at different cycles.
        push_job(1, 1, 11, 1'b0);
        start_job(1, 4, 10, 4, 10);
        wait_done(100);

        // Three tiles, plus an ignored start mid-job.
        push_job(3, 3, 9, 1'b0);
        start_job(3, 2, 2, 2, 2);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);

        // Sinks not ready: hold in WAIT without pulses.
        sink_rdy = '0;
        push_job(1, 1, 4, 1'b0);
        start_job(1, 3, 3, 3, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wait_noreq", {src_req, sink_req, eng_start}, 5'h0);
            chk("wait_ctl", {busy, eng_enable, eng_clear}, 3'b100);
            @(posedge clk); #1;
        end
        sink_rdy = '1;
        wait_done(100);

        // n_tiles 0 behaves as 1.
        push_job(1, 1, 2, 1'b0);
        start_job(0, 1, 1, 1, 1);
        wait_done(100);

        // Zero limits complete on the first COMPUTE cycle.
        push_job(2, 2, 2, 1'b0);
        start_job(2, 0, 0, 0, 0);
        wait_done(100);

        // Clear mid-COMPUTE on a job that would never finish.
        start_job(1, 5, 5, 3, 3);
        repeat (4) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_busy", busy, 1'b0);
        chk("clr_ctl", {eng_clear, eng_enable}, 2'b11);
        chk("clr_no_done", done, 1'b0);
        chk("clr_tile_idx", tile_idx, 16'd0);
        @(posedge clk); #1;

`ifdef MULTI_DATAFLOW_CTRL_WDOG_EN
        // Stalled engine trips the watchdog after 16 stalled cycles.
        eng_ready = 1'b0;
        push_job(0, 1, 16, 1'b1);
        start_job(1, 5, 5, 3, 3);
        wait_done(200);
        eng_ready = 1'b1;
        @(negedge clk);
        chk("wdog_err_sticky", error, 1'b1);
        @(posedge clk); #1;
        push_job(1, 1, 3, 1'b0);
        start_job(1, 2, 2, 2, 2);
        @(negedge clk);
        chk("wdog_err_cleared", error, 1'b0);
        wait_done(100);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
